// File: rtl/byte_mem_pkg.sv
// ---------------------------------------------------------------------------
// byte_mem_pkg
//   Shared types and sizes for the byte memory host: the controller state
//   enum and the memory geometry (32 bytes, 5-bit address, 8-bit data).
// ---------------------------------------------------------------------------
package byte_mem_pkg;

    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        DUMP_RD = 3'd3,
        DUMP_TX = 3'd4
    } state_t;

endpackage

// File: rtl/byte_mem_host_if.sv
// ---------------------------------------------------------------------------
// byte_mem_host_if
//   Bundles the load stream, the core memory bus, the dump stream and the
//   status outputs of byte_mem_host.
//
//   Handshake rule for both streams: a beat transfers on a rising clock edge
//   where valid and ready are both high; while valid is high and ready is low
//   the source holds valid and its payload stable.
//
//   Modports:
//     slave  - the memory host (receives load beats, drives dump beats)
//     master - the environment (load source, core, dump sink)
//   dbg_state exposes the controller state for observation only.
// ---------------------------------------------------------------------------
interface byte_mem_host_if #(
    parameter int ADDR_W = byte_mem_pkg::ADDR_W,
    parameter int DATA_W = byte_mem_pkg::DATA_W
);
    import byte_mem_pkg::*;

    // load stream
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    // core memory bus
    logic              cpu_start;
    logic              cpu_halt;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    // dump stream
    logic              dump_valid;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;
    logic              dump_ready;
    // status
    logic              busy;
    logic              timeout;
    state_t            dbg_state;

    modport slave (
        input  load_valid, load_data, load_last,
        output load_ready,
        output cpu_start, cpu_rdata,
        input  cpu_halt, cpu_addr, cpu_we, cpu_wdata,
        output dump_valid, dump_data, dump_last,
        input  dump_ready,
        output busy, timeout, dbg_state
    );

    modport master (
        output load_valid, load_data, load_last,
        input  load_ready,
        input  cpu_start, cpu_rdata,
        output cpu_halt, cpu_addr, cpu_we, cpu_wdata,
        input  dump_valid, dump_data, dump_last,
        output dump_ready,
        input  busy, timeout, dbg_state
    );

endinterface

// File: rtl/byte_mem_ram.sv
// ---------------------------------------------------------------------------
// byte_mem_ram
//   DEPTH x DW RAM, one write port and one synchronous read port.
//   A read and a write to the same address in the same cycle returns the
//   old contents. The array itself is not reset; only the read register is.
//
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset (read register)
//     we/waddr/wdata write port
//     re/raddr       read request; rdata is valid the cycle after re
//     rdata          read register, holds its value while re is low
// ---------------------------------------------------------------------------
module byte_mem_ram
    import byte_mem_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = ADDR_W,
    parameter int DW    = DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/byte_mem_host.sv
// ---------------------------------------------------------------------------
// byte_mem_host
//   Byte memory and run controller for the byte computer. Loads a program
//   image over the load stream starting at address 0, releases the core
//   (cpu_start) and serves its reads/writes until cpu_halt, then streams
//   all DEPTH bytes out over the dump stream and returns to IDLE.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous reset, active low
//     bus    byte_mem_host_if.slave: load stream, core bus, dump stream,
//            busy, timeout, dbg_state
//
//   Build option: BYTE_MEM_WATCHDOG_EN adds a run-cycle watchdog that ends
//   RUN after WDOG_CYCLES cycles without halt and sets the sticky timeout.
//   Without it, timeout stays 0 and there is no counter.
// ---------------------------------------------------------------------------
module byte_mem_host
    import byte_mem_pkg::*;
#(
    parameter int DEPTH       = MEM_DEPTH,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic     clk,
    input  logic     rst_n,
    byte_mem_host_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 2");
    end

    state_t        state, state_n;
    logic [AW-1:0] load_ptr, load_ptr_n;
    logic [AW-1:0] dump_ptr, dump_ptr_n;
    logic          timeout_q, timeout_n;
    logic          ready_en;      // keeps load_ready low until reset is released
    logic          rdata_is_cpu;  // RAM read register currently holds a core read
    logic [7:0]    cpu_hold;      // last core read, shown while not in RUN
    logic          wdog_fire;
    logic          load_ready;
    logic          load_acc;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [7:0]    ram_rdata;

    byte_mem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (8)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign load_ready = ready_en && ((state == IDLE) || (state == LOAD));
    assign load_acc   = bus.load_valid && load_ready;

`ifdef BYTE_MEM_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES);
    logic [WW-1:0] wdog_cnt;

    // Counts RUN cycles; cleared whenever the core is not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (state == RUN) begin
            wdog_cnt <= wdog_cnt + WW'(1);
        end else begin
            wdog_cnt <= '0;
        end
    end

    assign wdog_fire = (state == RUN) && (wdog_cnt == WW'(WDOG_CYCLES - 1));
`else
    assign wdog_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            load_ptr     <= '0;
            dump_ptr     <= '0;
            timeout_q    <= 1'b0;
            ready_en     <= 1'b0;
            rdata_is_cpu <= 1'b0;
            cpu_hold     <= '0;
        end else begin
            state     <= state_n;
            load_ptr  <= load_ptr_n;
            dump_ptr  <= dump_ptr_n;
            timeout_q <= timeout_n;
            ready_en  <= 1'b1;
            // The shared read register is taken over by the dump on the
            // first DUMP_RD; save the last core read there so cpu_rdata
            // keeps showing it outside RUN.
            if (state == RUN) begin
                rdata_is_cpu <= 1'b1;
            end else if (state == DUMP_RD) begin
                rdata_is_cpu <= 1'b0;
                if (rdata_is_cpu) begin
                    cpu_hold <= ram_rdata;
                end
            end
        end
    end

    always_comb begin
        state_n    = state;
        load_ptr_n = load_ptr;
        dump_ptr_n = dump_ptr;
        timeout_n  = timeout_q;
        ram_we     = 1'b0;
        ram_waddr  = load_ptr;
        ram_wdata  = bus.load_data;
        ram_re     = 1'b0;
        ram_raddr  = dump_ptr;

        case (state)
            IDLE: begin
                if (load_acc) begin
                    ram_we     = 1'b1;
                    ram_waddr  = '0;
                    load_ptr_n = AW'(1);
                    timeout_n  = 1'b0;
                    state_n    = bus.load_last ? RUN : LOAD;
                end
            end
            LOAD: begin
                if (load_acc) begin
                    ram_we     = 1'b1;
                    load_ptr_n = load_ptr + AW'(1);
                    if (bus.load_last || (load_ptr == LAST_ADDR)) begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                ram_we    = bus.cpu_we;
                ram_waddr = bus.cpu_addr;
                ram_wdata = bus.cpu_wdata;
                ram_re    = 1'b1;
                ram_raddr = bus.cpu_addr;
                // Halt has priority over a watchdog expiry in the same cycle.
                if (bus.cpu_halt) begin
                    dump_ptr_n = '0;
                    state_n    = DUMP_RD;
                end else if (wdog_fire) begin
                    dump_ptr_n = '0;
                    timeout_n  = 1'b1;
                    state_n    = DUMP_RD;
                end
            end
            DUMP_RD: begin
                ram_re  = 1'b1;
                state_n = DUMP_TX;
            end
            DUMP_TX: begin
                if (bus.dump_ready) begin
                    if (dump_ptr == LAST_ADDR) begin
                        state_n = IDLE;
                    end else begin
                        dump_ptr_n = dump_ptr + AW'(1);
                        state_n    = DUMP_RD;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.load_ready = load_ready;
    assign bus.cpu_start  = (state == RUN);
    assign bus.cpu_rdata  = rdata_is_cpu ? ram_rdata : cpu_hold;
    assign bus.dump_valid = (state == DUMP_TX);
    assign bus.dump_data  = (state == DUMP_TX) ? ram_rdata : '0;
    assign bus.dump_last  = (state == DUMP_TX) && (dump_ptr == LAST_ADDR);
    assign bus.busy       = (state != IDLE);
    assign bus.timeout    = timeout_q;
    assign bus.dbg_state  = state;

endmodule
